gcd_core: RTL and testbench

Iterative 16-bit GCD engine (repeated-subtraction Euclid) built as a controller FSM plus a datapath with A/B registers, subtractor and comparator. Both operands arrive serially on one input bus after a start request. The result is presented with a level done flag. Sits as a standalone arithmetic helper on a shared clock.

---
 rtl/gcd_core.sv | 124 ++++++++++++
 tb/tb_gcd_core.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gcd_core.sv
// Iterative repeated-subtraction GCD engine: serial A/B load, one compare/subtract step per cycle.
// Optional GCD_ITER_COUNT_EN adds an iter_count output counting subtraction steps.
module gcd_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] result
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [15:0]      iter_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_busy;
`ifdef GCD_ITER_COUNT_EN
    logic [15:0]      r_iter;
`endif

    logic             w_a_zero;
    logic             w_b_zero;
    logic             w_eq;
    logic             w_a_gt_b;
    logic [WIDTH-1:0] w_a_minus_b;
    logic [WIDTH-1:0] w_b_minus_a;

    assign w_a_zero    = (r_a == '0);
    assign w_b_zero    = (r_b == '0);
    assign w_eq        = (r_a == r_b);
    assign w_a_gt_b    = (r_a > r_b);
    assign w_a_minus_b = r_a - r_b;
    assign w_b_minus_a = r_b - r_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
            r_iter   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_LOAD_A;
                        r_busy   <= 1'b1;
                        r_result <= '0;
`ifdef GCD_ITER_COUNT_EN
                        r_iter   <= '0;
`endif
                    end
                end
                S_LOAD_A: begin
                    r_a     <= data_in;
                    r_state <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    r_b     <= data_in;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // Zero/equal checks take priority; the larger operand is always the minuend.
                    if (w_a_zero || w_b_zero || w_eq) begin
                        r_result <= w_a_zero ? r_b : r_a;
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        if (w_a_gt_b) begin
                            r_a <= w_a_minus_b;
                        end else begin
                            r_b <= w_b_minus_a;
                        end
`ifdef GCD_ITER_COUNT_EN
                        if (r_iter != 16'hFFFF) begin
                            r_iter <= r_iter + 16'd1;
                        end
`endif
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign done   = r_done;
    assign busy   = r_busy;
    assign result = r_result;
`ifdef GCD_ITER_COUNT_EN
    assign iter_count = r_iter;
`endif

endmodule

// File: tb/tb_gcd_core.sv
// Randomized self-checking bench for gcd_core against a division-based Euclid model.
// Also exercises iter_count when GCD_ITER_COUNT_EN is defined.
module tb_gcd_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic        done;
    logic        busy;
    logic [15:0] result;
`ifdef GCD_ITER_COUNT_EN
    logic [15:0] iter_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    gcd_core #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .done    (done),
        .busy    (busy),
        .result  (result)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_count (iter_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Subtractive Euclid performs (sum of division quotients - 1) subtractions for nonzero inputs.
    function automatic int unsigned ref_steps(input int unsigned a, input int unsigned b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned q_sum = 0;
        int unsigned t;
        if (a == 0 || b == 0) return 0;
        if (x < y) begin
            t = x; x = y; y = t;
        end
        while (y != 0) begin
            q_sum += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        return q_sum - 1;
    endfunction

    task automatic run_op(input int unsigned a, input int unsigned b);
        int unsigned exp_g;
        int unsigned exp_s;
        int unsigned cyc;
        bit          seen;
        exp_g = ref_gcd(a, b);
        exp_s = ref_steps(a, b);
        start   = 1'b1;
        data_in = 16'(a);
        @(posedge clk); #1;
        check("load_a_busy", busy, 1);
        check("load_a_result", result, 0);
        @(posedge clk); #1;
        data_in = 16'(b);
        check("load_b_result", result, 0);
        check("load_b_done", done, 0);
        @(posedge clk); #1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < exp_s + 20) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) seen = 1'b1;
        end
        check("latency", cyc, exp_s + 1);
        check("result", result, exp_g);
        check("done_busy", busy, 0);
`ifdef GCD_ITER_COUNT_EN
        check("iter_count", iter_count, exp_s);
`endif
        @(posedge clk); #1;
        check("done_hold", done, 1);
        check("result_hold", result, exp_g);
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int unsigned ra;
        int unsigned rb;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        @(posedge clk); #1;
        check("idle_stay_busy", busy, 0);

        run_op(143, 78);
        run_op(100, 75);
        run_op(48, 18);
        run_op(7, 7);
        run_op(0, 25);
        run_op(25, 0);
        run_op(0, 0);

        for (int i = 0; i < 25; i++) begin
            ra = $urandom_range(0, 1023);
            rb = $urandom_range(0, 1023);
            if (i % 8 == 3) ra = 0;
            run_op(ra, rb);
        end

        // Reset in the middle of a long RUN must discard the computation.
        start   = 1'b1;
        data_in = 16'd1000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_in = 16'd1;
        repeat (12) @(posedge clk);
        #1;
        check("midrun_busy", busy, 1);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
`ifdef GCD_ITER_COUNT_EN
        check("midrst_iter", iter_count, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        check("postrst_busy", busy, 0);

        run_op(65535, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
